// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and the debug port.
// Define DMEM_DBG_PRIORITY_EN to make debug win every tie; otherwise ties alternate round-robin.
module dmem_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [DATA_W/8-1:0]   cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  dbg_req,
    input  logic [DATA_W/8-1:0]   dbg_we,
    input  logic [ADDR_W-1:0]     dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  dbg_ack,
    output logic                  mem_en,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t           state;
    logic             owner;
    logic             last_owner;
    logic             keep;
    logic [CNT_W-1:0] count;
    logic             grant_dbg;
    logic             owner_req;

    // owner and last_owner use 1 for the debug port, 0 for the CPU
    always_comb begin
        grant_dbg = 1'b0;
`ifdef DMEM_DBG_PRIORITY_EN
        grant_dbg = dbg_req;
`else
        grant_dbg = dbg_req & (~cpu_req | ~last_owner);
`endif
    end

    assign owner_req = owner ? dbg_req : cpu_req;
    assign cpu_stall = rst & cpu_req & ~((state == RESP) & ~owner);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            keep       <= 1'b0;
            count      <= '0;
            mem_en     <= 1'b0;
            mem_we     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
            dbg_ack    <= 1'b0;
        end else begin
            mem_en  <= 1'b0;
            dbg_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req | dbg_req) begin
                        owner      <= grant_dbg;
                        last_owner <= grant_dbg;
                        mem_we     <= grant_dbg ? dbg_we    : cpu_we;
                        mem_addr   <= grant_dbg ? dbg_addr  : cpu_addr;
                        mem_wdata  <= grant_dbg ? dbg_wdata : cpu_wdata;
                        mem_en     <= 1'b1;
                        count      <= CNT_W'(MEM_LATENCY - 1);
                        keep       <= 1'b1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // an owner that lets go mid-access still finishes on the memory but gets nothing back
                    keep <= keep & owner_req;
                    if (count == '0) begin
                        if (keep & owner_req & (mem_we == BE_W'(0))) begin
                            if (owner) dbg_rdata <= mem_rdata;
                            else       cpu_rdata <= mem_rdata;
                        end
                        dbg_ack <= owner & keep & owner_req;
                        state   <= RESP;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
